// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// FSM states, default register-index width and the control-output bundles.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam int REG_W_DEF = 4;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic md_busy;
    } ctrl_t;

    // Forced while rst_n is low: everything frozen and every buffer cleared to a bubble.
    localparam ctrl_t CTRL_RESET = '{
        pc_write:    1'b0,
        ifid_write:  1'b0,
        idex_write:  1'b0,
        ifid_flush:  1'b1,
        idex_flush:  1'b1,
        exmem_flush: 1'b1,
        md_busy:     1'b0
    };

    localparam ctrl_t CTRL_ADVANCE = '{
        pc_write:    1'b1,
        ifid_write:  1'b1,
        idex_write:  1'b1,
        ifid_flush:  1'b0,
        idex_flush:  1'b0,
        exmem_flush: 1'b0,
        md_busy:     1'b0
    };

    localparam ctrl_t CTRL_MD_STALL = '{
        pc_write:    1'b0,
        ifid_write:  1'b0,
        idex_write:  1'b0,
        ifid_flush:  1'b0,
        idex_flush:  1'b0,
        exmem_flush: 1'b1,
        md_busy:     1'b1
    };

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating event counter with synchronous active-low clear; used for the
// hazard controller's optional performance counters (HAZARD_PERF_EN).
module hazard_perf_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_clr_n,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the five-stage pipeline: load-use bubbles,
// taken-branch flushes and multi-cycle mul/div holds. Perf counters under HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int REG_W         = pipe_ctrl_pkg::REG_W_DEF,
    parameter int MULDIV_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] ifid_rs,
    input  logic [REG_W-1:0] ifid_rt,
    input  logic             ifid_uses_rt,
    input  logic [REG_W-1:0] idex_rt,
    input  logic             idex_memread,
    input  logic             idex_muldiv,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             md_busy,
    output logic [15:0]      stall_cycles,
    output logic [15:0]      flush_events
);

    import pipe_ctrl_pkg::*;

    // The detection cycle is stall #0, so the counter starts two below the occupancy.
    localparam logic [3:0] CNT_LOAD = 4'(MULDIV_CYCLES - 2);

    state_t     r_state;
    logic [3:0] r_cnt;
    ctrl_t      w_ctrl;
    logic       w_load_use;

    assign w_load_use = idex_memread &&
                        ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

    always_comb begin
        w_ctrl = CTRL_ADVANCE;
        if (!rst_n) begin
            w_ctrl = CTRL_RESET;
        end else if (branch_taken) begin
            w_ctrl.ifid_flush = 1'b1;
            w_ctrl.idex_flush = 1'b1;
        end else if (r_state == RUN) begin
            if (idex_muldiv) begin
                w_ctrl = CTRL_MD_STALL;
            end else if (w_load_use) begin
                w_ctrl.pc_write   = 1'b0;
                w_ctrl.ifid_write = 1'b0;
                w_ctrl.idex_flush = 1'b1;
            end
        end else if (r_cnt != 4'd0) begin
            w_ctrl = CTRL_MD_STALL;
        end else begin
            w_ctrl.md_busy = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else if (branch_taken) begin
            r_state <= RUN;
            r_cnt   <= 4'd0;
        end else if (r_state == RUN) begin
            if (idex_muldiv) begin
                r_state <= MD_BUSY;
                r_cnt   <= CNT_LOAD;
            end
        end else if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end else begin
            r_state <= RUN;
        end
    end

    assign pc_write    = w_ctrl.pc_write;
    assign ifid_write  = w_ctrl.ifid_write;
    assign idex_write  = w_ctrl.idex_write;
    assign ifid_flush  = w_ctrl.ifid_flush;
    assign idex_flush  = w_ctrl.idex_flush;
    assign exmem_flush = w_ctrl.exmem_flush;
    assign md_busy     = w_ctrl.md_busy;

`ifdef HAZARD_PERF_EN
    hazard_perf_counter #(.WIDTH(16)) u_stall_cnt (
        .i_clk   (clk),
        .i_clr_n (rst_n),
        .i_inc   (!w_ctrl.pc_write),
        .o_count (stall_cycles)
    );

    hazard_perf_counter #(.WIDTH(16)) u_flush_cnt (
        .i_clk   (clk),
        .i_clr_n (rst_n),
        .i_inc   (w_ctrl.ifid_flush),
        .o_count (flush_events)
    );
`else
    assign stall_cycles = 16'h0000;
    assign flush_events = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios plus random traffic,
// checked against a cycle-phase reference model; also exercises counter saturation.
module tb_pipe_hazard_ctrl;

    localparam int REG_W = 4;
    localparam int MC    = 4;
    localparam int SW    = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] ifid_rs, ifid_rt, idex_rt;
    logic             ifid_uses_rt, idex_memread, idex_muldiv, branch_taken;
    logic             pc_write, ifid_write, idex_write;
    logic             ifid_flush, idex_flush, exmem_flush, md_busy;
    logic [15:0]      stall_cycles, flush_events;
    logic             sat_clr_n, sat_inc;
    logic [SW-1:0]    sat_count;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(REG_W), .MULDIV_CYCLES(MC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .ifid_uses_rt (ifid_uses_rt),
        .idex_rt      (idex_rt),
        .idex_memread (idex_memread),
        .idex_muldiv  (idex_muldiv),
        .branch_taken (branch_taken),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .idex_write   (idex_write),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    hazard_perf_counter #(.WIDTH(SW)) u_sat (
        .i_clk   (clk),
        .i_clr_n (sat_clr_n),
        .i_inc   (sat_inc),
        .o_count (sat_count)
    );

    typedef struct packed {
        logic [31:0]   cyc;
        logic [6:0]    ctl;
        logic [15:0]   stall;
        logic [15:0]   flush;
        logic [SW-1:0] sat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: md_phase = cycles elapsed since the mul/div was detected (0 = none).
    int md_phase = 0;
    int m_stall  = 0;
    int m_flush  = 0;
    int m_sat    = 0;
    int cyc      = 0;

    task automatic step(input logic r, input logic [3:0] rs, input logic [3:0] rt,
                        input logic uses, input logic [3:0] irt, input logic mem,
                        input logic md, input logic br, input logic sclr, input logic sinc);
        logic pw, iw, xw, ff, xf, ef, mb;
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r; ifid_rs = rs; ifid_rt = rt; ifid_uses_rt = uses; idex_rt = irt;
        idex_memread = mem; idex_muldiv = md; branch_taken = br;
        sat_clr_n = sclr; sat_inc = sinc;
        pw = 1; iw = 1; xw = 1; ff = 0; xf = 0; ef = 0; mb = 0;
        if (!r) begin
            pw = 0; iw = 0; xw = 0; ff = 1; xf = 1; ef = 1;
            md_phase = 0;
        end else if (br) begin
            ff = 1; xf = 1;
            md_phase = 0;
        end else if (md_phase > 0) begin
            mb = 1;
            if (md_phase < MC - 1) begin
                pw = 0; iw = 0; xw = 0; ef = 1;
                md_phase = md_phase + 1;
            end else begin
                md_phase = 0;
            end
        end else if (md) begin
            pw = 0; iw = 0; xw = 0; ef = 1; mb = 1;
            md_phase = 1;
        end else if (mem && ((irt == rs) || (uses && (irt == rt)))) begin
            pw = 0; iw = 0; xf = 1;
        end
        e.cyc = cyc;
        e.ctl = {pw, iw, xw, ff, xf, ef, mb};
`ifdef HAZARD_PERF_EN
        e.stall = m_stall[15:0];
        e.flush = m_flush[15:0];
`else
        e.stall = 16'h0000;
        e.flush = 16'h0000;
`endif
        e.sat = m_sat[SW-1:0];
        if (!r) begin
            m_stall = 0; m_flush = 0;
        end else begin
            if (!pw && m_stall < 65535) m_stall = m_stall + 1;
            if (ff && m_flush < 65535) m_flush = m_flush + 1;
        end
        if (!sclr) m_sat = 0;
        else if (sinc && m_sat < (1 << SW) - 1) m_sat = m_sat + 1;
        sb_q.push_back(e);
        cyc = cyc + 1;
    endtask

    task automatic idle(input logic md);
        step(1, 4'd1, 4'd2, 0, 4'd3, 0, md, 0, 1, 1);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if ({pc_write, ifid_write, idex_write, ifid_flush, idex_flush, exmem_flush, md_busy} !== e.ctl) begin
                    n_fail++;
                    $display("FAIL ctrl cyc=%0d got=%b expected=%b (pc,ifid,idex,ifl,ixfl,exfl,busy)",
                             e.cyc, {pc_write, ifid_write, idex_write, ifid_flush, idex_flush,
                                     exmem_flush, md_busy}, e.ctl);
                end
                n_checks++;
                if ({stall_cycles, flush_events} !== {e.stall, e.flush}) begin
                    n_fail++;
                    $display("FAIL perf cyc=%0d got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                             e.cyc, stall_cycles, flush_events, e.stall, e.flush);
                end
                n_checks++;
                if (sat_count !== e.sat) begin
                    n_fail++;
                    $display("FAIL satcnt cyc=%0d got=%0d expected=%0d", e.cyc, sat_count, e.sat);
                end
            end
        end
    end

    initial begin
        rst_n = 0; ifid_rs = 0; ifid_rt = 0; ifid_uses_rt = 0; idex_rt = 0;
        idex_memread = 0; idex_muldiv = 0; branch_taken = 0; sat_clr_n = 0; sat_inc = 0;
        @(posedge clk);

        // reset held three cycles, then release
        repeat (3) step(0, 4'd4, 4'd4, 1, 4'd4, 1, 1, 1, 0, 0);
        idle(0);
        // load-use via rt, then load leaves EX
        step(1, 4'd9, 4'd4, 1, 4'd4, 1, 0, 0, 1, 1);
        idle(0);
        // same registers but rt unused: no stall
        step(1, 4'd9, 4'd4, 0, 4'd4, 1, 0, 0, 1, 1);
        // rs match on register 0 and on register 15
        step(1, 4'd0, 4'd7, 0, 4'd0, 1, 0, 0, 1, 1);
        step(1, 4'd15, 4'd7, 0, 4'd15, 1, 0, 0, 1, 1);
        // mul/div held: stall 0-2, release 3, then RUN
        repeat (4) idle(1);
        idle(0);
        // branch in cycle 1 of a hold
        idle(1);
        step(1, 4'd1, 4'd2, 0, 4'd3, 0, 1, 1, 1, 1);
        idle(0);
        // branch + mul/div + load-use together
        step(1, 4'd5, 4'd5, 1, 4'd5, 1, 1, 1, 1, 1);
        idle(0);
        // back-to-back mul/div
        repeat (8) idle(1);
        idle(0);
        // reset in cycle 2 of a hold
        idle(1);
        idle(1);
        step(0, 4'd1, 4'd2, 0, 4'd3, 0, 1, 0, 1, 1);
        idle(0);
        // load-use suppressed during a hold
        idle(1);
        repeat (3) step(1, 4'd6, 4'd6, 1, 4'd6, 1, 0, 0, 1, 1);
        // saturate the narrow counter
        repeat (20) idle(0);

        for (int i = 0; i < 600; i++) begin
            logic [3:0] rs, rt, irt;
            if ($urandom_range(0, 3) == 0) begin
                rs = 4'($urandom); rt = 4'($urandom); irt = 4'($urandom);
            end else begin
                rs = 4'($urandom_range(0, 3)); rt = 4'($urandom_range(0, 3)); irt = 4'($urandom_range(0, 3));
            end
            step(($urandom_range(0, 39) != 0), rs, rt, 1'($urandom), irt,
                 ($urandom_range(0, 4) < 2), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 15) != 0),
                 ($urandom_range(0, 3) != 0));
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain got=%0d pending expected=0 pending", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 16-bit five-stage pipeline. It owns the write-enable and flush controls of the PC, IF/ID and ID/EX buffers, plus the bubble control of EX/MEM. It inserts load-use bubbles, flushes wrong-path instructions on a taken branch, and holds the pipeline while a multi-cycle multiply/divide occupies EX. It sits beside the ID stage and drives the IDEX_FLUSH input of the ID/EX buffer.

## Interface
Parameters:
- REG_W, 4, register-index width (16 registers)
- MULDIV_CYCLES, 4, EX occupancy of a mul/div op; legal range 2..15

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- ifid_rs  in  REG_W  rs field of the instruction in ID
- ifid_rt  in  REG_W  rt field of the instruction in ID
- ifid_uses_rt  in  1  the ID instruction reads rt
- idex_rt  in  REG_W  destination of the instruction in EX
- idex_memread  in  1  the EX instruction is a load
- idex_muldiv  in  1  the EX instruction is a mul/div
- branch_taken  in  1  a branch resolved taken in EX this cycle
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- idex_write  out  1  ID/EX load enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_flush  out  1  clear ID/EX controls to zero (bubble)
- exmem_flush  out  1  load a bubble into EX/MEM
- md_busy  out  1  mul/div hold in progress
- stall_cycles  out  16  perf count of stall cycles (see Configuration)
- flush_events  out  16  perf count of branch flushes (see Configuration)

## Operation
- States: RUN and MD_BUSY. There is a 4-bit down-counter cnt.
- Outputs are combinational from state, cnt and inputs.
- Default outputs (advance): pc_write=ifid_write=idex_write=1; all flushes 0; md_busy 0.
- Priority in RUN: branch_taken, then idex_muldiv, then load-use.
- Branch (RUN or MD_BUSY):
  - Outputs: ifid_flush=1, idex_flush=1, pc_write=1, exmem_flush=0.
  - Next state is RUN with cnt=0; this aborts any mul/div hold.
- Mul/div (RUN, idex_muldiv=1):
  - Stall outputs: pc_write=ifid_write=idex_write=0, exmem_flush=1, md_busy=1.
  - cnt<=MULDIV_CYCLES-2; next state MD_BUSY.
- MD_BUSY, cnt!=0:
  - Stall outputs as above; cnt<=cnt-1.
  - Load-use detection is suppressed.
- MD_BUSY, cnt==0:
  - Default (advance) outputs, with md_busy=1.
  - Next state RUN. This is the release cycle; the mul/div result enters EX/MEM.
- Load-use (RUN) triggers when idex_memread=1 and either condition holds:
  - idex_rt==ifid_rs, or
  - ifid_uses_rt=1 and idex_rt==ifid_rt.
- Load-use response:
  - One bubble: pc_write=0, ifid_write=0, idex_flush=1.
  - idex_write and exmem_flush stay at their defaults.
  - The state does not change. The condition clears on its own once the load leaves EX.
- Register compare covers all 16 indices; no register is exempt.

## Timing
- While rst_n=0 at a rising edge, the next state is RUN and cnt=0.
- While rst_n=0, outputs are forced to: pc_write=0, ifid_write=0, idex_write=0, ifid_flush=1, idex_flush=1, exmem_flush=1, md_busy=0.
- Perf counters clear to 0 under reset.
- Load-use costs exactly 1 bubble cycle.
- A taken branch costs 2 flushed slots (IF and ID), asserted in a single cycle.
- A mul/div holds for exactly MULDIV_CYCLES-1 stall cycles, then releases in cycle MULDIV_CYCLES-1 (counting from 0 at first detection).
- The release cycle is not re-detected as a new mul/div: the state is MD_BUSY, and the next RUN cycle sees the following instruction in EX.
- Back-to-back mul/div: the second op is detected in the first RUN cycle after release.
- Reset asserted mid-hold returns to RUN at the next edge.

## Configuration
- HAZARD_PERF_EN defined:
  - stall_cycles increments on every cycle with pc_write=0 while rst_n=1.
  - flush_events increments on every cycle with ifid_flush=1 while rst_n=1.
  - Both counters saturate at 16'hFFFF.
- HAZARD_PERF_EN undefined: both ports are tied to 16'h0000 and no counter flops exist.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, MD_BUSY);
  - the REG_W default;
  - the output reset-value constants.
- Sub-module hazard_perf_counter: a 16-bit saturating counter with synchronous active-low clear and an increment enable. It is instantiated twice, only under HAZARD_PERF_EN.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> flushes=1, writes=0, md_busy=0, counters 0. Release -> default advance outputs.
- Load-use: idex_memread=1, idex_rt=4, ifid_rs=9, ifid_rt=4, ifid_uses_rt=1 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1. Repeat with ifid_uses_rt=0 -> no stall.
- Mul/div, MULDIV_CYCLES=4: assert idex_muldiv=1 held -> stall for cycles 0-2, release in cycle 3 (md_busy=1, writes=1), then RUN; stall_cycles=3.
- Branch during hold: branch_taken=1 in cycle 1 of a mul/div -> same cycle ifid_flush=idex_flush=1, pc_write=1. Next cycle is RUN; flush_events=1.
- Simultaneous events: branch_taken, idex_muldiv and a load-use match all in one RUN cycle -> branch response only, state stays RUN.
- Reset mid-hold: rst_n=0 in cycle 2 of a mul/div -> next edge in RUN with cnt=0, md_busy=0.
